kmer_sequencer: RTL and testbench

Front end of the k-mer counting pipeline. Accepts a stream of ASCII nucleotides per read, 2-bit encodes them into a sliding K-base window, and emits each complete k-mer with its in-read position on `rg_out`. For each k-mer it sequences the six-phase hash, read, modify and write cycle of the downstream counter/SRAM stage, driving that stage's strobes and the dual-port SRAM controls.

---
 rtl/kmer_pkg.sv | 33 +++
 rtl/kmer_window.sv | 83 ++++++++
 rtl/kmer_sequencer.sv | 152 +++++++++++++++
 tb/tb_kmer_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kmer_pkg.sv
// Shared types, base codes and defaults for the k-mer front end.
package kmer_pkg;

    localparam int DEF_K     = 45;
    localparam int DEF_POS_W = 8;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        HASH,
        ADDR,
        READ,
        GET,
        SET,
        WRITE
    } kseq_state_t;

    // Returns {invalid, code}; anything outside ACGT/acgt is flagged invalid.
    function automatic logic [2:0] encode_base(input logic [7:0] b);
        case (b)
            "A", "a": return {1'b0, BASE_A};
            "C", "c": return {1'b0, BASE_C};
            "G", "g": return {1'b0, BASE_G};
            "T", "t": return {1'b0, BASE_T};
            default:  return 3'b100;
        endcase
    endfunction

endpackage

// File: rtl/kmer_window.sv
// Sliding 2-bit k-mer window with fill/index tracking and emit detection.
// KMER_CANONICAL_EN builds a reverse-complement register and emits min(fwd, rc).
module kmer_window
    import kmer_pkg::*;
#(
    parameter int K     = DEF_K,
    parameter int POS_W = DEF_POS_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               take,
    input  logic [7:0]         data,
    input  logic               clear,
    output logic               emit,
    output logic               discard,
    output logic [POS_W-1:0]   pos,
    output logic [2*K-1:0]     kmer
);

    localparam int FILL_W = $clog2(K + 1);

    logic [2*K-1:0]    win;
    logic [2*K-1:0]    win_shift;
    logic [FILL_W-1:0] fill;
    logic [POS_W:0]    idx;
    logic [2:0]        enc;
    logic              invalid;
    logic [1:0]        code;

    assign enc       = encode_base(data);
    assign invalid   = enc[2];
    assign code      = enc[1:0];
    assign win_shift = {win[2*K-3:0], code};

    // Once idx reaches 2^POS_W it saturates; everything after is dropped.
    assign discard = take && idx[POS_W];
    assign emit    = take && !discard && !invalid && (fill >= FILL_W'(K - 1));
    assign pos     = idx[POS_W-1:0] - POS_W'(K - 1);

`ifdef KMER_CANONICAL_EN
    logic [2*K-1:0] rc;
    logic [2*K-1:0] rc_shift;

    assign rc_shift = {~code, rc[2*K-1:2]};
    assign kmer     = (rc_shift < win_shift) ? rc_shift : win_shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rc <= '0;
        end else if (take && !discard && !invalid) begin
            rc <= rc_shift;
        end
    end
`else
    assign kmer = win_shift;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win  <= '0;
            fill <= '0;
            idx  <= '0;
        end else if (clear) begin
            fill <= '0;
            idx  <= '0;
        end else if (take) begin
            if (!idx[POS_W]) begin
                idx <= idx + (POS_W + 1)'(1);
            end
            if (!discard) begin
                if (invalid) begin
                    fill <= '0;
                end else begin
                    win <= win_shift;
                    if (fill != FILL_W'(K)) begin
                        fill <= fill + FILL_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/kmer_sequencer.sv
// K-mer sequencer top: base intake, k-mer emission and the six-phase counter/SRAM sequence.
// Optional macro KMER_CANONICAL_EN selects canonical (min of forward/reverse-complement) k-mers.
module kmer_sequencer
    import kmer_pkg::*;
#(
    parameter int K     = DEF_K,
    parameter int POS_W = DEF_POS_W,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   base_valid,
    output logic                   base_ready,
    input  logic [7:0]             base_data,
    input  logic                   base_last,
    output logic [POS_W+2*K-1:0]   rg_out,
    output logic                   EN_LFSR,
    output logic                   read_add,
    output logic                   get_row,
    output logic                   set_row,
    output logic                   CSB1,
    output logic                   OEB1,
    output logic                   WEB1,
    output logic                   CSB2,
    output logic                   OEB2,
    output logic                   WEB2,
    output logic                   read_done,
    output logic [CNT_W-1:0]       kmer_count,
    output logic                   pos_overflow
);

    kseq_state_t      state;
    kseq_state_t      state_next;
    logic             end_pend;
    logic             accept;
    logic             clear;
    logic             emit;
    logic             discard;
    logic [POS_W-1:0] pos;
    logic [2*K-1:0]   kmer;
    logic             en_lfsr_n, read_add_n, get_row_n, set_row_n;
    logic             csb1_n, oeb1_n, web1_n, csb2_n, oeb2_n, web2_n;

    // The read_done pulse cycle is the IDLE cycle with end_pend still set.
    assign base_ready = (state == IDLE) && !end_pend;
    assign accept     = base_valid && base_ready;
    assign clear      = (state == IDLE) && end_pend;

    kmer_window #(
        .K     (K),
        .POS_W (POS_W)
    ) u_window (
        .clk     (clk),
        .reset   (reset),
        .take    (accept),
        .data    (base_data),
        .clear   (clear),
        .emit    (emit),
        .discard (discard),
        .pos     (pos),
        .kmer    (kmer)
    );

    always_comb begin
        state_next = state;
        en_lfsr_n  = 1'b0;
        read_add_n = 1'b0;
        get_row_n  = 1'b0;
        set_row_n  = 1'b0;
        csb1_n     = 1'b1;
        oeb1_n     = 1'b1;
        web1_n     = 1'b1;
        csb2_n     = 1'b1;
        oeb2_n     = 1'b1;
        web2_n     = 1'b1;
        case (state)
            IDLE:    if (emit) state_next = HASH;
            HASH:    state_next = ADDR;
            ADDR:    state_next = READ;
            READ:    state_next = GET;
            GET:     state_next = SET;
            SET:     state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Strobes are decoded from the next state so they come out registered.
        case (state_next)
            HASH:  en_lfsr_n  = 1'b1;
            ADDR:  read_add_n = 1'b1;
            READ: begin
                csb1_n = 1'b0;
                oeb1_n = 1'b0;
            end
            GET:   get_row_n  = 1'b1;
            SET:   set_row_n  = 1'b1;
            WRITE: begin
                csb2_n = 1'b0;
                web2_n = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            end_pend     <= 1'b0;
            rg_out       <= '0;
            EN_LFSR      <= 1'b0;
            read_add     <= 1'b0;
            get_row      <= 1'b0;
            set_row      <= 1'b0;
            CSB1         <= 1'b1;
            OEB1         <= 1'b1;
            WEB1         <= 1'b1;
            CSB2         <= 1'b1;
            OEB2         <= 1'b1;
            WEB2         <= 1'b1;
            read_done    <= 1'b0;
            kmer_count   <= '0;
            pos_overflow <= 1'b0;
        end else begin
            state     <= state_next;
            EN_LFSR   <= en_lfsr_n;
            read_add  <= read_add_n;
            get_row   <= get_row_n;
            set_row   <= set_row_n;
            CSB1      <= csb1_n;
            OEB1      <= oeb1_n;
            WEB1      <= web1_n;
            CSB2      <= csb2_n;
            OEB2      <= oeb2_n;
            WEB2      <= web2_n;
            read_done <= (accept && base_last && !emit) || ((state == WRITE) && end_pend);
            if (emit) begin
                rg_out <= {pos, kmer};
            end
            if (state == WRITE) begin
                kmer_count <= kmer_count + CNT_W'(1);
            end
            if (discard) begin
                pos_overflow <= 1'b1;
            end
            if (accept && base_last) begin
                end_pend <= 1'b1;
            end else if (clear) begin
                end_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kmer_sequencer.sv
// Self-checking bench for kmer_sequencer: directed reads plus random reads against a queue-based model.
module tb_kmer_sequencer;

    localparam int K     = 45;
    localparam int POS_W = 8;
    localparam int CNT_W = 16;
    localparam int RW    = POS_W + 2 * K;
    localparam logic [9:0] ST_IDLE = 10'b0000_111_111;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             base_valid = 1'b0;
    logic             base_ready;
    logic [7:0]       base_data = 8'h00;
    logic             base_last = 1'b0;
    logic [RW-1:0]    rg_out;
    logic             EN_LFSR, read_add, get_row, set_row;
    logic             CSB1, OEB1, WEB1, CSB2, OEB2, WEB2;
    logic             read_done;
    logic [CNT_W-1:0] kmer_count;
    logic             pos_overflow;
    logic [9:0]       strobes;

    int               vectors = 0;
    int               miscompares = 0;
    int               m_idx = 0;
    int               m_count = 0;
    bit               m_ovf = 1'b0;
    logic [1:0]       q[$];
    logic [POS_W-1:0] dut_last_pos = '0;

    kmer_sequencer #(.K(K), .POS_W(POS_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .base_valid   (base_valid),
        .base_ready   (base_ready),
        .base_data    (base_data),
        .base_last    (base_last),
        .rg_out       (rg_out),
        .EN_LFSR      (EN_LFSR),
        .read_add     (read_add),
        .get_row      (get_row),
        .set_row      (set_row),
        .CSB1         (CSB1),
        .OEB1         (OEB1),
        .WEB1         (WEB1),
        .CSB2         (CSB2),
        .OEB2         (OEB2),
        .WEB2         (WEB2),
        .read_done    (read_done),
        .kmer_count   (kmer_count),
        .pos_overflow (pos_overflow)
    );

    assign strobes = {EN_LFSR, read_add, get_row, set_row, CSB1, OEB1, WEB1, CSB2, OEB2, WEB2};

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] phase_strobes(input int p);
        case (p)
            0:       return 10'b1000_111_111;
            1:       return 10'b0100_111_111;
            2:       return 10'b0000_001_111;
            3:       return 10'b0010_111_111;
            4:       return 10'b0001_111_111;
            5:       return 10'b0000_111_010;
            default: return ST_IDLE;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [7:0] b, output bit emit, output logic [RW-1:0] rg);
        logic [1:0]     code;
        bit             valid;
        logic [2*K-1:0] fw;
        logic [2*K-1:0] rc;
        emit  = 1'b0;
        rg    = '0;
        valid = 1'b1;
        code  = 2'd0;
        case (b)
            "A", "a": code = 2'd0;
            "C", "c": code = 2'd1;
            "G", "g": code = 2'd2;
            "T", "t": code = 2'd3;
            default:  valid = 1'b0;
        endcase
        if (m_idx >= (1 << POS_W)) begin
            m_ovf = 1'b1;
        end else if (!valid) begin
            q.delete();
        end else begin
            q.push_back(code);
            if (q.size() > K) void'(q.pop_front());
            if (q.size() == K) begin
                fw = '0;
                rc = '0;
                foreach (q[i]) fw = {fw[2*K-3:0], q[i]};
                for (int i = K - 1; i >= 0; i--) rc = {rc[2*K-3:0], ~q[i]};
`ifdef KMER_CANONICAL_EN
                if (rc < fw) fw = rc;
`endif
                emit = 1'b1;
                rg   = {POS_W'(m_idx - (K - 1)), fw};
                m_count++;
            end
        end
        m_idx++;
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        bit            emit;
        logic [RW-1:0] rg;
        int            n;
        base_valid = 1'b1;
        base_data  = b;
        base_last  = last;
        n = 0;
        while (!base_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before", base_ready, 1);
        @(posedge clk);
        model(b, emit, rg);
        @(negedge clk);
        base_valid = 1'b0;
        base_last  = 1'b0;
        if (emit) begin
            for (int p = 0; p < 6; p++) begin
                if (p > 0) @(negedge clk);
                chk("phase_strobes", strobes, phase_strobes(p));
                chk("ready_busy", base_ready, 0);
                if (p == 0 || p == 5) chk("rg_out", rg_out, rg);
            end
            dut_last_pos = rg_out[RW-1:2*K];
            @(negedge clk);
        end
        chk("kmer_count", kmer_count, m_count);
        chk("pos_overflow", pos_overflow, m_ovf);
        chk("idle_strobes", strobes, ST_IDLE);
        chk("read_done", read_done, last);
        if (last) begin
            chk("ready_in_done", base_ready, 0);
            @(negedge clk);
            m_idx = 0;
            q.delete();
            chk("read_done_clear", read_done, 0);
        end
        chk("ready_after", base_ready, 1);
    endtask

    task automatic random_read(input int len, input int n_rate);
        string alpha = "ACGTacgt";
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(n_rate - 1, 0) == 0) b = "N";
            else b = alpha[$urandom_range(7, 0)];
            send(b, i == len - 1);
        end
    endtask

    initial begin
        logic [2*K-1:0] ones = '1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rg_out", rg_out, 0);
        chk("rst_strobes", strobes, ST_IDLE);
        chk("rst_count", kmer_count, 0);
        chk("rst_read_done", read_done, 0);
        chk("rst_ovf", pos_overflow, 0);
        chk("rst_ready", base_ready, 1);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < K; i++) send("A", i == K - 1);
        chk("single_rg", rg_out, 0);
        chk("single_count", kmer_count, 1);

        send("C", 1'b0);
        for (int i = 0; i < K; i++) send("A", i == K - 1);
        chk("slide_pos", dut_last_pos, 1);
        chk("slide_kmer", rg_out[2*K-1:0], 0);

        for (int i = 0; i < K - 1; i++) send("G", 1'b0);
        send("N", 1'b0);
        for (int i = 0; i < K; i++) send("T", i == K - 1);
        chk("invalid_count", kmer_count, 4);
        chk("invalid_pos", dut_last_pos, 45);
`ifdef KMER_CANONICAL_EN
        chk("t_kmer", rg_out[2*K-1:0], 0);
`else
        chk("t_kmer", rg_out[2*K-1:0], ones);
`endif

        random_read(300, 1000);
        chk("long_ovf", pos_overflow, 1);
        chk("long_last_pos", dut_last_pos, 211);

        for (int r = 0; r < 5; r++) random_read($urandom_range(110, 40), 30);

        for (int i = 0; i < K - 1; i++) send("A", 1'b0);
        base_valid = 1'b1;
        base_data  = "A";
        @(posedge clk);
        @(negedge clk);
        base_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_read", strobes, phase_strobes(2));
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_strobes", strobes, ST_IDLE);
        chk("mid_rst_count", kmer_count, 0);
        chk("mid_rst_rg", rg_out, 0);
        m_idx = 0;
        m_count = 0;
        m_ovf = 1'b0;
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_wr_port", {CSB2, WEB2}, 2'b11);
            chk("post_rst_ready", base_ready, 1);
            chk("post_rst_count", kmer_count, 0);
        end
        for (int i = 0; i < K; i++) send("C", i == K - 1);
        chk("recover_count", kmer_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
